seq_calculator: RTL and testbench

Multi-cycle, parametrised arithmetic unit that replaces the fixed 4-bit combinational operation bank feeding the board's LED/seven-segment display path. It takes two WIDTH-bit operands and an opcode on a start pulse, runs single-cycle or iterative (shift-add / restoring) datapaths, and returns a registered 2*WIDTH-bit result with a done pulse and error flag. The result drives the existing binary-to-BCD display chain unchanged.

---
 rtl/seq_calculator.sv | 182 ++++++++++++++++++
 tb/tb_seq_calculator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_calculator.sv
// Multi-cycle arithmetic unit: add/sub/compare in one RUN cycle; multiply, divide and sqrt iterate one bit per cycle.
// Optional feature macro: CALC_SQRT_EN enables the op 5 square-root datapath; otherwise op 5 is illegal.
module seq_calculator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_DIV  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_REM  = 4'd4;
  localparam logic [3:0] OP_SQRT = 4'd5;
  localparam logic [3:0] OP_CMP  = 4'd6;
  localparam logic [3:0] OP_SQA  = 4'd7;
  localparam logic [3:0] OP_SQB  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            iter;
  logic [3:0]      op_q;
  logic [WIDTH-1:0] a_q, b_q;
  // acc: product / partial remainder; opa: shifted multiplicand / radicand; opb: multiplier / dividend-quotient / root
  logic [RW-1:0]   acc;
  logic [RW-1:0]   opa;
  logic [WIDTH-1:0] opb;

  logic [RW-1:0]   mul_next;
  logic [WIDTH:0]  div_sh;
  logic            div_ge;
  logic [WIDTH:0]  div_rem;
  logic [RW-1:0]   fin_result;
  logic            fin_err;

  function automatic logic is_iter(input logic [3:0] o);
    case (o)
      OP_DIV, OP_MUL, OP_REM, OP_SQA, OP_SQB: is_iter = 1'b1;
`ifdef CALC_SQRT_EN
      OP_SQRT: is_iter = 1'b1;
`endif
      default: is_iter = 1'b0;
    endcase
  endfunction

  // One shift-add step and one restoring-division step
  always_comb begin
    mul_next = acc + (opb[0] ? opa : '0);
    div_sh   = {acc[WIDTH-1:0], opb[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_rem  = div_ge ? (div_sh - {1'b0, b_q}) : div_sh;
  end

`ifdef CALC_SQRT_EN
  logic [WIDTH+3:0] sq_sh;
  logic [WIDTH+3:0] sq_trial;
  logic             sq_ge;
  logic [WIDTH+3:0] sq_rem;

  // One digit-by-digit root step: bring down two radicand bits, try 4*root+1
  always_comb begin
    sq_sh    = {acc[WIDTH+1:0], opa[RW-1:RW-2]};
    sq_trial = {2'b00, opb, 2'b01};
    sq_ge    = (sq_sh >= sq_trial);
    sq_rem   = sq_ge ? (sq_sh - sq_trial) : sq_sh;
  end
`endif

  // Final result selection on the done edge
  always_comb begin
    fin_result = '0;
    fin_err    = 1'b0;
    case (op_q)
      OP_ADD: fin_result = RW'(a_q) + RW'(b_q);
      OP_SUB: fin_result = RW'(a_q) - RW'(b_q);
      OP_CMP: fin_result = RW'({a_q > b_q, a_q == b_q, a_q < b_q});
      OP_DIV: begin
        fin_result = RW'(opb);
        fin_err    = (b_q == '0);
      end
      OP_REM: begin
        fin_result = RW'(acc[WIDTH-1:0]);
        fin_err    = (b_q == '0);
      end
      OP_MUL, OP_SQA, OP_SQB: fin_result = acc;
`ifdef CALC_SQRT_EN
      OP_SQRT: fin_result = RW'(opb);
`endif
      default: fin_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      iter   <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            err   <= 1'b0;
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            iter  <= is_iter(op);
            cnt   <= is_iter(op) ? CW'(WIDTH - 1) : '0;
            acc   <= '0;
            case (op)
              OP_MUL: begin opa <= RW'(a); opb <= b; end
              OP_SQA: begin opa <= RW'(a); opb <= a; end
              OP_SQB: begin opa <= RW'(b); opb <= b; end
              OP_DIV, OP_REM: begin opa <= '0; opb <= a; end
              OP_SQRT: begin opa <= {b, a}; opb <= '0; end
              default: begin opa <= '0; opb <= '0; end
            endcase
          end
        end
        S_RUN: begin
          if (iter) begin
            case (op_q)
              OP_MUL, OP_SQA, OP_SQB: begin
                acc <= mul_next;
                opa <= opa << 1;
                opb <= opb >> 1;
              end
              OP_DIV, OP_REM: begin
                acc <= RW'(div_rem);
                opb <= {opb[WIDTH-2:0], div_ge};
              end
`ifdef CALC_SQRT_EN
              OP_SQRT: begin
                acc <= RW'(sq_rem);
                opa <= opa << 2;
                opb <= {opb[WIDTH-2:0], sq_ge};
              end
`endif
              default: ;
            endcase
            if (cnt == '0) iter <= 1'b0;
            else           cnt  <= cnt - CW'(1);
          end else begin
            result <= fin_result;
            err    <= fin_err;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator (WIDTH=4): arithmetic model checked every cycle plus literal directed vectors.
module tb_seq_calculator;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, err;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  seq_calculator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  typedef struct packed {
    logic [7:0] r;
    logic       e;
    logic [5:0] lat;
  } exp_t;

  // Expected result, error and accept-to-done latency from plain arithmetic
  function automatic exp_t model_eval(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
    exp_t t;
    int ix, iy, v, s;
    ix = int'(x);
    iy = int'(y);
    t.r = '0;
    t.e = 1'b0;
    t.lat = 6'd1;
    case (o)
      4'd0: t.r = 8'(ix + iy);
      4'd1: t.r = 8'(ix - iy);
      4'd6: t.r = {5'b0, x > y, x == y, x < y};
      4'd2: begin
        t.lat = 6'(W + 1);
        if (iy == 0) begin t.r = 8'd15; t.e = 1'b1; end
        else t.r = 8'(ix / iy);
      end
      4'd4: begin
        t.lat = 6'(W + 1);
        if (iy == 0) begin t.r = 8'(ix); t.e = 1'b1; end
        else t.r = 8'(ix % iy);
      end
      4'd3: begin t.lat = 6'(W + 1); t.r = 8'(ix * iy); end
      4'd7: begin t.lat = 6'(W + 1); t.r = 8'(ix * ix); end
      4'd8: begin t.lat = 6'(W + 1); t.r = 8'(iy * iy); end
`ifdef CALC_SQRT_EN
      4'd5: begin
        t.lat = 6'(W + 1);
        v = iy * 16 + ix;
        s = 0;
        while ((s + 1) * (s + 1) <= v) s++;
        t.r = 8'(s);
      end
`endif
      default: t.e = 1'b1;
    endcase
    return t;
  endfunction

  exp_t cur;
  always_comb cur = model_eval(op, a, b);

  logic       m_busy, m_done, m_err;
  logic [7:0] m_result, p_result;
  logic       p_err;
  int         m_left;

  // Transaction-level model of the visible outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_result <= '0;
      m_left <= 0; p_result <= '0; p_err <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_result <= p_result; m_err <= p_err;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        p_result <= cur.r; p_err <= cur.e; m_left <= int'(cur.lat);
        m_busy <= 1'b1; m_err <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (done) done_count++;
    chk("cyc_busy",   32'(busy),   32'(m_busy));
    chk("cyc_done",   32'(done),   32'(m_done));
    chk("cyc_err",    32'(err),    32'(m_err));
    chk("cyc_result", 32'(result), 32'(m_result));
  end

  // Issue one op, optionally poke start mid-run, then check literal result and latency
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [3:0] top,
                        input logic [7:0] exp_r, input logic exp_e, input int exp_lat,
                        input int poke, input bit now);
    int n;
    if (!now) @(negedge clk);
    a = ta; b = tb_v; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = (n == poke) && !done;
      if (start) begin a = 4'd1; b = 4'd1; op = 4'd0; end
    end while (!done && n < 40);
    start = 1'b0;
    chk("latency", 32'(n), 32'(exp_lat));
    chk("result",  32'(result), 32'(exp_r));
    chk("err",     32'(err), 32'(exp_e));
  endtask

  initial begin
    int dc;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd15, 4'd15, 4'd3, 8'd225, 1'b0, 5, 0, 1'b0);
    run_op(4'd15, 4'd0,  4'd7, 8'd225, 1'b0, 5, 0, 1'b0);
    run_op(4'd2,  4'd7,  4'd8, 8'd49,  1'b0, 5, 0, 1'b0);
    run_op(4'd13, 4'd4,  4'd2, 8'd3,   1'b0, 5, 0, 1'b0);
    run_op(4'd13, 4'd4,  4'd4, 8'd1,   1'b0, 5, 0, 1'b0);
    run_op(4'd9,  4'd0,  4'd2, 8'd15,  1'b1, 5, 0, 1'b0);
    run_op(4'd9,  4'd0,  4'd4, 8'd9,   1'b1, 5, 0, 1'b0);
    run_op(4'd3,  4'd5,  4'd1, 8'hFE,  1'b0, 1, 0, 1'b0);
    run_op(4'd3,  4'd5,  4'd0, 8'd8,   1'b0, 1, 0, 1'b0);
    run_op(4'd3,  4'd5,  4'd6, 8'h01,  1'b0, 1, 0, 1'b0);
    run_op(4'd7,  4'd7,  4'd6, 8'h02,  1'b0, 1, 0, 1'b0);
    run_op(4'd3,  4'd5,  4'd12, 8'd0,  1'b1, 1, 0, 1'b0);
`ifdef CALC_SQRT_EN
    run_op(4'd8,  4'd12, 4'd5, 8'd14,  1'b0, 5, 0, 1'b0);
`else
    run_op(4'd8,  4'd12, 4'd5, 8'd0,   1'b1, 1, 0, 1'b0);
`endif
    // Mid-run start is ignored, then a start in the done cycle is taken back-to-back
    run_op(4'd15, 4'd15, 4'd3, 8'd225, 1'b0, 5, 2, 1'b0);
    run_op(4'd13, 4'd4,  4'd2, 8'd3,   1'b0, 5, 0, 1'b1);

    // Reset mid-multiply aborts with no done
    @(negedge clk);
    a = 4'd15; b = 4'd15; op = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dc = done_count;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 32'(done_count), 32'(dc));
    run_op(4'd15, 4'd15, 4'd3, 8'd225, 1'b0, 5, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
